bd_rx_sync: RTL and testbench
=============================

Name: bd_rx_sync

Overview:
- Clocked receiving end of a 4-phase bundled-data channel. The sending side drives `data_in`, then `req_in` through a matched delay element.
- The block synchronises `req_in`, captures the bundled data into a 1-entry output register, returns `ack_out`, and presents the word on a synchronous valid/ready interface.
- Sits at the async-to-sync boundary, consumed by clocked logic.

Parameters:
- WIDTH, 8: bundled data width.
- SYNC_STAGES, 2: flip-flop stages on `req_in` (legal range 2..4).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_in  in  1  async 4-phase request; `data_in` is stable while it is high.
- data_in  in  WIDTH  bundled data; unsynchronised, sampled only on capture.
- ack_out  out  1  4-phase acknowledge, driven from a flop (glitch-free).
- out_valid  out  1  `out_data` holds an unconsumed word.
- out_data  out  WIDTH  captured word.
- out_ready  in  1  consumer accepts the word when `out_valid && out_ready`.
- err  out  1  protocol error flag; only present with `BD_RX_ERR_EN`.

Interface note: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (`rst_n`=0, asynchronous):
  - sync chain cleared; state=IDLE.
  - `ack_out`=0, `out_valid`=0, `out_data`=0, `err`=0.
- Synchroniser:
  - `req_s` = `req_in` after SYNC_STAGES flops.
  - No other async input is ever synchronised.
  - `data_in` is safe because its capture is gated on `req_s`, which lags `req_in`.
- `slot_free` = `!out_valid || out_ready`.
- FSM, 2 states:
  - IDLE (`ack_out`=0):
    - if `req_s`=1 and `slot_free`: capture on this edge.
      - `out_data` <= `data_in`, `out_valid` <= 1, `ack_out` <= 1.
      - -> ACK_HI.
    - if `req_s`=1 and not `slot_free`: stay in IDLE, no capture, `ack_out` stays 0. This back-pressures the sender.
  - ACK_HI (`ack_out`=1):
    - when `req_s`=0: `ack_out` <= 0, -> IDLE.
    - otherwise hold.
- Output register:
  - `out_valid` clears on `out_valid && out_ready` unless a capture happens on the same edge.
  - Simultaneous consume + capture: `out_valid` stays 1 and `out_data` takes the new word.
  - `out_data` never changes while `out_valid`=1 and `out_ready`=0.
- Latency: `req_in` rise sampled at edge E0 -> `req_s`=1 after E(SYNC_STAGES-1) -> `out_valid`/`ack_out` high after edge E(SYNC_STAGES). That is SYNC_STAGES+1 clocks when the slot is free.
- Throughput: at most 1 word per 2*(SYNC_STAGES+1) clocks plus sender delays.
- `req_s` re-rising while in ACK_HI is impossible under the protocol. If it happens, it is ignored until IDLE is re-entered.
- `out_ready` is ignored while `out_valid`=0.
- Reset mid-transfer:
  - drops `ack_out` immediately and discards any held word.
  - the sender must complete its return-to-zero.
  - if `req_in` is still high after reset release, the word is re-captured (a duplicate is accepted by design).

Optional Feature:
- Macro: `BD_RX_ERR_EN`.
- With the macro:
  - `err` port exists.
  - `err` sets (sticky, cleared only by `rst_n`) when, in IDLE with `out_valid`=1, `req_s` falls after having been high without a capture. That is a sender withdrawing a request it was never acknowledged for.
  - An extra 1-bit flop tracks "req seen in IDLE".
- Without the macro: no `err` port, no tracking flop; behaviour otherwise identical.

Decomposition:
- Shared async_lib package holds:
  - enum `bd_rx_state_t` {IDLE, ACK_HI}.
  - constant `BD_SYNC_MIN`=2.
- One sub-module: `sync_ff` (SYNC_STAGES-deep 1-bit synchroniser, async active-low reset). It is reusable by the future transmit-side block for `ack` synchronisation.

Test Plan:
1. Reset value: hold `rst_n`=0 with `req_in`=1 -> `ack_out`=0, `out_valid`=0, `out_data`=0. Release -> `out_valid`=1 with `out_data`=`data_in` exactly SYNC_STAGES+1 clocks later.
2. Single word: `out_ready`=1, SYNC_STAGES=2, `data_in`=0xA5, `req_in` rises -> `out_valid`/`ack_out` high on the 3rd edge, `out_data`=0xA5. Drop `req_in` -> `ack_out`=0 three edges later.
3. Back-pressure: `out_ready`=0.
   - Word 0x11 is captured.
   - Second request with 0x22 -> `ack_out` stays 0 and `out_data` stays 0x11.
   - Raise `out_ready` for one cycle -> same-edge swap to 0x22, `out_valid` remains 1.
4. Stream: 16 words 0x00..0x0F with a random sender delay of 0-5 clocks and random `out_ready` -> scoreboard sees all 16 in order, none lost or duplicated, `ack_out` toggles 32 times.
5. Mid-transfer reset: assert `rst_n` while in ACK_HI -> `ack_out` falls asynchronously and `out_valid`=0. Sender completes return-to-zero -> next word 0x5A is received normally.
6. `BD_RX_ERR_EN`: with `out_valid` held, `req_in` pulses high for 5 clocks then low without an ack -> `err`=1 and stays 1 until reset. Without the macro, the build has no `err` port and the same stimulus causes no hang.

Source files
------------

// File: rtl/async_lib_pkg.sv
// async_lib_pkg: shared types and constants for the async-boundary blocks.
package async_lib_pkg;
  typedef enum logic {IDLE = 1'b0, ACK_HI = 1'b1} bd_rx_state_t;
  localparam int BD_SYNC_MIN = 2;
  localparam int BD_SYNC_MAX = 4;
  function automatic int clamp_stages(input int n);
    return n < BD_SYNC_MIN ? BD_SYNC_MIN : n > BD_SYNC_MAX ? BD_SYNC_MAX : n;
  endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep 1-bit synchroniser with asynchronous active-low reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/bd_rx_sync.sv
// bd_rx_sync: 4-phase bundled-data receiver into a 1-entry valid/ready register.
// Optional sticky protocol-error output `err` when BD_RX_ERR_EN is defined.
module bd_rx_sync
  import async_lib_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef BD_RX_ERR_EN
  ,
  output logic             err
`endif
);
  localparam int N = clamp_stages(SYNC_STAGES);
  bd_rx_state_t state, state_nx;
  logic req_s, slot_free, capture, out_valid_nx;
  logic [WIDTH-1:0] out_data_nx;
  sync_ff #(.STAGES(N)) u_req_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (req_in),
    .q    (req_s)
  );
  assign slot_free = !out_valid || out_ready;
  // data_in is only sampled here, after req_s has lagged req_in by N flops
  always_comb begin
    capture      = (state == IDLE) && req_s && slot_free;
    state_nx     = state == IDLE ? (capture ? ACK_HI : IDLE) : (req_s ? ACK_HI : IDLE);
    out_valid_nx = capture ? 1'b1 : (out_valid && out_ready) ? 1'b0 : out_valid;
    out_data_nx  = capture ? data_in : out_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      ack_out   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nx;
      ack_out   <= state_nx == ACK_HI;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
    end
`ifdef BD_RX_ERR_EN
  logic seen, seen_nx, err_nx;
  // seen: request observed in IDLE that has not been captured yet
  always_comb begin
    seen_nx = (state == IDLE) && req_s && !capture;
    err_nx  = err || ((state == IDLE) && seen && !req_s && out_valid);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seen <= 1'b0;
      err  <= 1'b0;
    end else begin
      seen <= seen_nx;
      err  <= err_nx;
    end
`endif
endmodule

// File: tb/tb_bd_rx_sync.sv
// tb_bd_rx_sync: directed + scoreboarded bench for bd_rx_sync (SYNC_STAGES=2).
module tb_bd_rx_sync;
  logic clk = 0, rst_n = 0, req_in = 0, rdy_d = 0, rdy_r = 0, rand_rdy = 0;
  logic [7:0] data_in = 0, out_data;
  logic ack_out, out_valid, out_ready;
  int errors = 0, checks = 0, ack_tog = 0, tog0;
  logic [7:0] exp_q[$], got_q[$];
`ifdef BD_RX_ERR_EN
  logic err;
`endif

  assign out_ready = rand_rdy ? rdy_r : rdy_d;

  bd_rx_sync #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .data_in  (data_in),
    .ack_out  (ack_out),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
`ifdef BD_RX_ERR_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;
  always @(ack_out) ack_tog++;
  always @(negedge clk) if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
  initial forever begin
    @(posedge clk);
    #1 rdy_r = 1'($urandom_range(0, 1));
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic v);
    int n = 0;
    while (ack_out !== v && n < 200) begin
      cyc(1);
      n++;
    end
    chk(v ? "ack_rise" : "ack_fall", ack_out, v);
  endtask

  task automatic send(input logic [7:0] w, input int d);
    cyc(d);
    data_in = w;
    req_in  = 1;
    exp_q.push_back(w);
    wait_ack(1);
    req_in = 0;
    wait_ack(0);
  endtask

  task automatic check_sb();
    logic [7:0] g;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      if (exp_q.size() == 0) chk("sb_extra", g, 32'hdead);
      else chk("sb_word", g, exp_q.pop_front());
    end
  endtask

  initial begin
    // 1: reset with req_in held high, then re-capture after release
    data_in = 8'h3c;
    req_in  = 1;
    cyc(3);
    chk("rst_ack", ack_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
`ifdef BD_RX_ERR_EN
    chk("rst_err", err, 0);
`endif
    rst_n = 1;
    cyc(2);
    chk("rel_valid_e2", out_valid, 0);
    cyc(1);
    chk("rel_valid_e3", out_valid, 1);
    chk("rel_data", out_data, 8'h3c);
    exp_q.push_back(8'h3c);
    rdy_d  = 1;
    req_in = 0;
    wait_ack(0);
    cyc(2);
    check_sb();
    // 2: single word latency
    data_in = 8'ha5;
    req_in  = 1;
    exp_q.push_back(8'ha5);
    cyc(2);
    chk("lat_valid_e2", out_valid, 0);
    cyc(1);
    chk("lat_valid_e3", out_valid, 1);
    chk("lat_ack_e3", ack_out, 1);
    chk("lat_data", out_data, 8'ha5);
    req_in = 0;
    cyc(2);
    chk("fall_ack_e2", ack_out, 1);
    cyc(1);
    chk("fall_ack_e3", ack_out, 0);
    check_sb();
    // 3: back-pressure and same-edge swap
    rdy_d = 0;
    send(8'h11, 0);
    data_in = 8'h22;
    req_in  = 1;
    exp_q.push_back(8'h22);
    cyc(6);
    chk("bp_ack", ack_out, 0);
    chk("bp_data", out_data, 8'h11);
    chk("bp_valid", out_valid, 1);
    rdy_d = 1;
    cyc(1);
    rdy_d = 0;
    chk("swap_valid", out_valid, 1);
    chk("swap_data", out_data, 8'h22);
    chk("swap_ack", ack_out, 1);
    req_in = 0;
    wait_ack(0);
    check_sb();
    // 6: withdrawn request while the slot is held
    data_in = 8'h99;
    req_in  = 1;
    cyc(5);
    req_in = 0;
    cyc(6);
    chk("wd_ack", ack_out, 0);
    chk("wd_data", out_data, 8'h22);
`ifdef BD_RX_ERR_EN
    chk("wd_err", err, 1);
`endif
    rdy_d = 1;
    cyc(3);
    check_sb();
    // 4: stream with random sender delay and random consumer
    tog0     = ack_tog;
    rand_rdy = 1;
    for (int i = 0; i < 16; i++) send(8'(i), $urandom_range(0, 5));
    chk("stream_toggles", ack_tog - tog0, 32);
    rand_rdy = 0;
    rdy_d    = 1;
    cyc(4);
    check_sb();
    chk("stream_left", exp_q.size(), 0);
`ifdef BD_RX_ERR_EN
    chk("err_sticky", err, 1);
`endif
    // 5: reset while in ACK_HI
    rdy_d   = 0;
    data_in = 8'h77;
    req_in  = 1;
    wait_ack(1);
    rst_n = 0;
    #1;
    chk("mid_rst_ack", ack_out, 0);
    chk("mid_rst_valid", out_valid, 0);
`ifdef BD_RX_ERR_EN
    chk("mid_rst_err", err, 0);
`endif
    req_in = 0;
    cyc(3);
    rst_n = 1;
    rdy_d = 1;
    cyc(3);
    chk("post_rst_valid", out_valid, 0);
    send(8'h5a, 1);
    cyc(3);
    check_sb();
    chk("final_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
